pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline, sitting beside the ID-stage instruction decoder and driving the PC, IF/ID and ID/EX register enables and flushes. It generalises the pipeline's stall and flush logic with a parametrised multi-cycle HI/LO unit sequencer, EX-stage forwarding selects, load-use detection and a saturating stall-cycle performance counter. Priority is fixed: taken branch, then mul/div structural stall, then load-use stall, then jump flush.

## Interface
- MULDIV_LAT, 4: cycles the mul/div unit stays busy after a start; legal range 1..255.
- REG_ADDR_W, 5: register-address width.
- STALL_CNT_W, 16: width of the stall counter.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset; all state cleared while low.
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  the ID instruction reads rs / rt.
- id_jump  in  1  ID holds J/JAL/JR/JALR (decoder PCSrc != 0).
- id_muldiv_start  in  1  ID holds mult/multu/div/divu.
- id_hilo_read  in  1  ID holds mfhi/mflo.
- ex_mem_read  in  1  EX holds a load.
- ex_rs, ex_rt  in  REG_ADDR_W  source registers of the EX instruction.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_reg_write, mem_rd  in  1, REG_ADDR_W  EX/MEM write-back info.
- wb_reg_write, wb_rd  in  1, REG_ADDR_W  MEM/WB write-back info.
- stat_clr  in  1  synchronous clear of stall_count.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID becomes bubble.
- idex_flush  out  1  ID/EX becomes bubble.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 WB, 10 MEM.
- muldiv_busy  out  1  sequencer in BUSY (registered).
- muldiv_done  out  1  one-cycle pulse on BUSY->IDLE (registered).
- stall_count  out  STALL_CNT_W  stall cycles since reset/clear.

## Operation
- load_use = ex_mem_read & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- md_stall = muldiv_busy & (id_muldiv_start | id_hilo_read).
- Taken branch: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; all stalls ignored this cycle.
- Else md_stall or load_use: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
- Else id_jump: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0.
- Else: pc_write=1, ifid_write=1, flushes 0.
- Forwarding (per operand, shown for a/ex_rs): 10 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs; else 01 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs; else 00. MEM beats WB when both match. Same for b/ex_rt.
- Sequencer states IDLE, BUSY. IDLE->BUSY when id_muldiv_start & !ex_branch_taken & !load_use; counter loads MULDIV_LAT-1. BUSY: counter decrements each cycle; at counter==0 next state IDLE, muldiv_done=1 for the following cycle. A start seen in BUSY is stalled (md_stall) and accepted on the first IDLE cycle.
- Taken branch during BUSY: flush as above; counter keeps running (the issuing instruction is already past ID).
- stall_count: +1 every cycle pc_write==0; saturates at all-ones; stat_clr has priority over increment (count becomes 0).

## Timing
- Reset values: state IDLE, counter 0, muldiv_busy 0, muldiv_done 0, stall_count 0. With idle inputs: pc_write=1, ifid_write=1, flushes 0, fwd 00.
- pc_write, ifid_write, flushes, fwd_a/b: combinational, same cycle as inputs.
- muldiv_busy high exactly MULDIV_LAT cycles starting the cycle after the accepting edge; muldiv_done high the cycle after busy falls.
- Load-use stall lasts exactly one cycle (load moves to MEM).
- reset_n asserted mid-BUSY: immediately IDLE, busy/done 0, pending stall released.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle, stall_count 0->1.
- Forwarding priority: mem_rd=wb_rd=ex_rs=5, both writes 1 -> fwd_a=10; mem_rd=0 -> fwd_a=01; all rd=0 -> 00.
- MULDIV_LAT=4: start in ID -> busy 4 cycles, done pulse cycle 5; mfhi in ID during busy -> stalls until busy falls, stall_count +4 max.
- Branch over stall: ex_branch_taken=1 with load_use=1 -> pc_write=1, ifid_flush=1, idex_flush=1, no sequencer start.
- Saturation/clear: STALL_CNT_W=4, 20 stall cycles -> stall_count=15; stat_clr with stall -> 0.
- reset_n low during BUSY -> busy=0, done=0, pc_write=1 the same cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage pipeline plus a HI/LO unit busy sequencer.
// Hazard outputs combinational; muldiv_busy/done and stall_count registered.
module pipeline_hazard_ctrl #(
   parameter int MULDIV_LAT  = 4,
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [REG_ADDR_W-1:0]  id_rs,
   input  logic [REG_ADDR_W-1:0]  id_rt,
   input  logic                   id_uses_rs,
   input  logic                   id_uses_rt,
   input  logic                   id_jump,
   input  logic                   id_muldiv_start,
   input  logic                   id_hilo_read,
   input  logic                   ex_mem_read,
   input  logic [REG_ADDR_W-1:0]  ex_rs,
   input  logic [REG_ADDR_W-1:0]  ex_rt,
   input  logic                   ex_branch_taken,
   input  logic                   mem_reg_write,
   input  logic [REG_ADDR_W-1:0]  mem_rd,
   input  logic                   wb_reg_write,
   input  logic [REG_ADDR_W-1:0]  wb_rd,
   input  logic                   stat_clr,
   output logic                   pc_write,
   output logic                   ifid_write,
   output logic                   ifid_flush,
   output logic                   idex_flush,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b,
   output logic                   muldiv_busy,
   output logic                   muldiv_done,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0]             LAT_M1    = 8'(MULDIV_LAT - 1);
   localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
   localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

   state_t     state, stateNxt;
   logic [7:0] cnt, cntNxt;
   logic       doneNxt;
   logic       loadUse, mdStall, mdAccept;

   function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] src);
      logic [1:0] sel;
      sel = 2'b00;
      if (mem_reg_write && mem_rd != '0 && mem_rd == src)
         sel = 2'b10;
      else if (wb_reg_write && wb_rd != '0 && wb_rd == src)
         sel = 2'b01;
      return sel;
   endfunction

   assign loadUse = ex_mem_read && (ex_rt != '0) &&
                    ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
   assign muldiv_busy = (state == BUSY);
   assign mdStall     = muldiv_busy && (id_muldiv_start || id_hilo_read);
   // A squashed or stalled ID instruction must not launch the unit.
   assign mdAccept    = (state == IDLE) && id_muldiv_start && !ex_branch_taken && !loadUse;

   assign fwd_a = fwdSel(ex_rs);
   assign fwd_b = fwdSel(ex_rt);

   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (mdStall || loadUse) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end else if (id_jump) begin
         ifid_flush = 1'b1;
      end
   end

   always_comb begin
      stateNxt = state;
      cntNxt   = cnt;
      doneNxt  = 1'b0;
      case (state)
         IDLE: begin
            if (mdAccept) begin
               stateNxt = BUSY;
               cntNxt   = LAT_M1;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               stateNxt = IDLE;
               doneNxt  = 1'b1;
            end else begin
               cntNxt = cnt - 8'd1;
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         muldiv_done <= 1'b0;
      end else begin
         state       <= stateNxt;
         cnt         <= cntNxt;
         muldiv_done <= doneNxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stall_count <= '0;
      else if (stat_clr)
         stall_count <= '0;
      else if (!pc_write && stall_count != STALL_MAX)
         stall_count <= stall_count + STALL_ONE;
   end

endmodule
